// File: rtl/gate_arbiter.sv
// gate_arbiter: two-requester round-robin arbiter feeding a registered bitwise logic unit.
// Optional per-requester grant counters are built only when GATE_ARB_STATS_EN is defined.
module gate_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  input  logic             rsp_ready,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state_q, state_d;
  logic last_q, last_d, id_q, id_d;
  logic [WIDTH-1:0] data_q, data_d, a, b, res;
  logic [2:0] op;
  logic accept, gnt1, fire;
  // rst_n gates accept so no ready is visible while reset is held
  assign accept = rst_n & ((state_q == IDLE) | rsp_ready);
  assign gnt1 = req1_valid & (~req0_valid | ~last_q);
  assign req0_ready = accept & req0_valid & ~gnt1;
  assign req1_ready = accept & req1_valid & gnt1;
  assign fire = req0_ready | req1_ready;
  assign op = gnt1 ? req1_op : req0_op;
  assign a = gnt1 ? req1_a : req0_a;
  assign b = gnt1 ? req1_b : req0_b;
  always_comb begin
    res = '0;
    case (op)
      3'd0: res = a & b;
      3'd1: res = a | b;
      3'd2: res = ~(a & b);
      3'd3: res = ~(a | b);
      3'd4: res = a ^ b;
      3'd5: res = ~(a ^ b);
      3'd6: res = ~a;
      3'd7: res = ~b;
      default: res = '0;
    endcase
  end
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    id_d = id_q;
    data_d = data_q;
    if (fire) begin
      state_d = HOLD;
      last_d = gnt1;
      id_d = gnt1;
      data_d = res;
    end else if (rsp_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      id_q <= 1'b0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      id_q <= id_d;
      data_q <= data_d;
    end
  end
  assign rsp_valid = (state_q == HOLD);
  assign rsp_id = id_q;
  assign rsp_data = data_q;
`ifdef GATE_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt1_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (req0_ready && cnt0_q != 16'hFFFF) cnt0_q <= cnt0_q + 16'd1;
      if (req1_ready && cnt1_q != 16'hFFFF) cnt1_q <= cnt1_q + 16'd1;
    end
  end
  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`else
  assign grant_cnt0 = '0;
  assign grant_cnt1 = '0;
`endif
endmodule

// File: tb/tb_gate_arbiter.sv
// tb_gate_arbiter: directed stimulus with a response scoreboard for gate_arbiter.
module tb_gate_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0] req0_op, req1_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b, rsp_data;
  logic rsp_valid, rsp_id, rsp_ready;
  logic [15:0] grant_cnt0, grant_cnt1;
  int total = 0, bad = 0;
  logic [8:0] q[$];
  logic [7:0] v4e [8] = '{8'h05, 8'hCF, 8'hFA, 8'h30, 8'hCA, 8'h35, 8'h3A, 8'hF0};

  always #5 clk = ~clk;

  gate_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [8:0] e;
    if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got id=%0d data=%h expected none", rsp_id, rsp_data);
      end else begin
        e = q.pop_front();
        chk("rsp", {7'b0, rsp_id, rsp_data}, {7'b0, e});
      end
    end
  end

  task automatic set0(input logic v, input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    req0_valid = v; req0_op = o; req0_a = a; req0_b = b;
  endtask

  task automatic set1(input logic v, input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    req1_valid = v; req1_op = o; req1_a = a; req1_b = b;
  endtask

  task automatic step(input string n, input logic e0, input logic e1, input logic [7:0] ed);
    @(negedge clk);
    chk({n, "_r0"}, {15'b0, req0_ready}, {15'b0, e0});
    chk({n, "_r1"}, {15'b0, req1_ready}, {15'b0, e1});
    if (e0 | e1) q.push_back({e1, ed});
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    q.delete();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rst_valid", {15'b0, rsp_valid}, 16'h0);
    chk("rst_id", {15'b0, rsp_id}, 16'h0);
    chk("rst_data", {8'b0, rsp_data}, 16'h0);
    chk("rst_r0", {15'b0, req0_ready}, 16'h0);
    chk("rst_r1", {15'b0, req1_ready}, 16'h0);
    chk("rst_cnt0", grant_cnt0, 16'h0);
    chk("rst_cnt1", grant_cnt1, 16'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  function automatic logic [15:0] st(input logic [15:0] v);
`ifdef GATE_ARB_STATS_EN
    return v;
`else
    return 16'h0 & v;
`endif
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    set0(0, 0, 0, 0); set1(0, 0, 0, 0); rsp_ready = 1'b0;
    @(posedge clk); #1;
    rst_pulse();
    // V1
    set0(1, 0, 8'hF0, 8'h3C); rsp_ready = 1'b1;
    step("v1", 1, 0, 8'h30);
    chk("v1_valid", {15'b0, rsp_valid}, 16'h1);
    set0(0, 0, 0, 0);
    step("v1_drain", 0, 0, 0);
    chk("v1_idle", {15'b0, rsp_valid}, 16'h0);
    // V2
    rst_pulse();
    set0(1, 1, 8'h0F, 8'hF0); set1(1, 4, 8'hAA, 8'hFF); rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) chk("v2_valid", {15'b0, rsp_valid}, 16'h1);
      step("v2", i[0] == 1'b0, i[0] == 1'b1, i[0] ? 8'h55 : 8'hFF);
    end
    set0(0, 0, 0, 0); set1(0, 0, 0, 0);
    step("v2_drain", 0, 0, 0);
    chk("v2_cnt0", grant_cnt0, st(16'd2));
    chk("v2_cnt1", grant_cnt1, st(16'd2));
    // V3
    set0(1, 2, 8'hF0, 8'h3C); rsp_ready = 1'b0;
    step("v3_load", 1, 0, 8'hCF);
    set0(0, 0, 0, 0); set1(1, 5, 8'hAA, 8'h0F);
    for (int i = 0; i < 5; i++) begin
      chk("v3_hold_valid", {15'b0, rsp_valid}, 16'h1);
      chk("v3_hold_data", {8'b0, rsp_data}, 16'h00CF);
      step("v3_stall", 0, 0, 0);
    end
    rsp_ready = 1'b1;
    step("v3_go", 0, 1, 8'h5A);
    set1(0, 0, 0, 0);
    step("v3_drain", 0, 0, 0);
    chk("v3_idle", {15'b0, rsp_valid}, 16'h0);
    // V4
    rst_pulse();
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set0(1, 3'(i), 8'hC5, 8'h0F);
      step("v4", 1, 0, v4e[i]);
    end
    set0(0, 0, 0, 0);
    step("v4_drain", 0, 0, 0);
    chk("v4_cnt0", grant_cnt0, st(16'd8));
    // V5
    set0(1, 6, 8'hC5, 8'h0F); rsp_ready = 1'b0;
    step("v5_load", 1, 0, 8'h3A);
    set0(0, 0, 0, 0);
    chk("v5_hold", {15'b0, rsp_valid}, 16'h1);
    #2 rst_n = 1'b0;
    q.delete();
    #1 chk("v5_async", {15'b0, rsp_valid}, 16'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    set1(1, 7, 8'hC5, 8'h0F); rsp_ready = 1'b1;
    step("v5_new", 0, 1, 8'hF0);
    set1(0, 0, 0, 0);
    step("v5_drain", 0, 0, 0);
    // V6
    rst_pulse();
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set0(i[0] == 1'b0, 0, 8'hC5, 8'h0F);
      set1(i[0] == 1'b1, 1, 8'hC5, 8'h0F);
      step("v6", i[0] == 1'b0, i[0] == 1'b1, i[0] ? 8'hCF : 8'h05);
    end
    set0(0, 0, 0, 0); set1(0, 0, 0, 0);
    step("v6_drain", 0, 0, 0);
    chk("v6_cnt0", grant_cnt0, st(16'd3));
    chk("v6_cnt1", grant_cnt1, st(16'd2));
    chk("q_empty", 16'(q.size()), 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gate_arbiter.md
GATE_ARBITER -- requirements
Module: gate_arbiter

Interface
REQ-001 Parameter WIDTH SHALL default to 8 and set the operand and result width.
REQ-002 Ports SHALL be, in order (clock and reset first):
- clk  input  1  single rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_op  input  3  requester 0 opcode.
- req0_a, req0_b  input  WIDTH  requester 0 operands.
- req0_ready  output  1  requester 0 request accepted this cycle.
- req1_valid, req1_op, req1_a, req1_b, req1_ready  same as requester 0, for requester 1.
- rsp_valid  output  1  result held and valid.
- rsp_id  output  1  requester index that owns the result.
- rsp_data  output  WIDTH  result.
- rsp_ready  input  1  consumer accepts the result.
- grant_cnt0, grant_cnt1  output  16  accepted-request counters (see Configuration).
REQ-003 Clock is clk; reset is rst_n, asynchronous, active-low; no other clock or reset exists.

Function
REQ-004 Opcodes, bitwise over WIDTH: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a, 7 NOT b.
REQ-005 FSM SHALL have two states: IDLE (no result held) and HOLD (result held, rsp_valid=1).
REQ-006 Accept is possible when state is IDLE, or when state is HOLD and rsp_ready=1 on the same cycle.
REQ-007 reqN_ready SHALL be combinational, asserted only for the granted requester, and only while accept is possible and reqN_valid=1.
REQ-008 A request fires when reqN_valid and reqN_ready are both 1; at most one request fires per cycle.
REQ-009 If exactly one requester is valid, that requester is granted.
REQ-010 If both are valid, the requester not in last_grant is granted; last_grant updates to the granted index on every fire.
REQ-011 On fire, the result and requester index SHALL be registered; rsp_valid, rsp_data and rsp_id update on the next rising edge (latency 1 cycle).
REQ-012 In HOLD with rsp_ready=0, rsp_data and rsp_id SHALL remain stable and no request fires.
REQ-013 HOLD with rsp_ready=1 and no request firing: go to IDLE and clear rsp_valid next cycle.
REQ-014 HOLD with rsp_ready=1 and a request firing: stay in HOLD and load the new result, giving one result per cycle.
REQ-015 rsp_ready in IDLE SHALL be ignored.
REQ-016 reqN_valid deasserting before fire SHALL drop that request without side effects.
REQ-017 rsp_data SHALL be exactly WIDTH bits; the NOT ops invert all WIDTH bits.

Reset
REQ-018 While rst_n=0 the block SHALL hold state IDLE, with rsp_valid=0, rsp_id=0, rsp_data=0, last_grant=1, grant_cnt0=0, grant_cnt1=0.
REQ-019 reqN_ready SHALL be 0 while rst_n=0.
REQ-020 Reset asserted in HOLD SHALL discard the held result; there is no replay after release.
REQ-021 The first cycle after reset release SHALL be a normal IDLE cycle; a valid request may fire in it.

Configuration
REQ-022 Macro GATE_ARB_STATS_EN defined: grant_cnt0 and grant_cnt1 count fires of requester 0 and requester 1 respectively, saturating at 16'hFFFF.
REQ-023 Macro GATE_ARB_STATS_EN undefined: the counter ports still exist, are tied to 0, and no counter registers are built.

Verification
REQ-024 Bench SHALL cover these directed scenarios:
- V1: WIDTH=8, req0 op=0 a=8'hF0 b=8'h3C, rsp_ready=1 -> req0_ready=1 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=8'h30.
- V2: both valid every cycle after reset, rsp_ready=1 -> grants alternate 0,1,0,1; one rsp per cycle; req1 op=4 a=8'hAA b=8'hFF gives 8'h55.
- V3: one result pending, rsp_ready=0 for 5 cycles with req1 valid -> rsp_data stable, req1_ready=0 throughout; rsp_ready=1 -> req1 fires that same cycle.
- V4: all 8 opcodes with a=8'hC5 b=8'h0F -> 05, CF, FA, 30, CA, 35, 3A, F0.
- V5: rst_n pulled low in HOLD, asynchronously mid-cycle -> rsp_valid=0 immediately; after release, the first response belongs to the new request only.
- V6: with GATE_ARB_STATS_EN, 3 req0 fires and 2 req1 fires -> grant_cnt0=3, grant_cnt1=2; without the macro -> both 0.
